// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// PcSequencer -- program counter sequencer with exception entry/return
//
// Holds the fetch address and walks it forward by 2 each cycle unless a
// control-flow request redirects it. Exceptions save the return address in
// epc and vector to EXC_VECTOR; rti returns through epc. A halt request
// freezes the sequencer until the next reset.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   stall       hold all state this cycle (requests ignored)
//   halt        enter HALTED (highest priority)
//   siic        take exception: epc <= pc+2, pc <= EXC_VECTOR
//   rti         return from exception: pc <= epc
//   jmp         unconditional jump to jmp_target
//   jmp_target  jump destination (bit 0 forced low)
//   br_taken    taken branch to br_target
//   br_target   branch destination (bit 0 forced low)
//   pc          current fetch address
//   pc_plus2    pc + 2, combinational, wraps modulo 2^16
//   epc         saved exception return address
//   halted      high while in HALTED
//   redirect    one-cycle pulse after a non-sequential pc load
//   misalign    one-cycle pulse after a jump/branch to an odd target
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        halt,
   input  logic        siic,
   input  logic        rti,
   input  logic        jmp,
   input  logic [15:0] jmp_target,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic [15:0] epc,
   output logic        halted,
   output logic        redirect,
   output logic        misalign
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] epc_q, epc_d;
   logic        redirect_q, redirect_d;
   logic        misalign_q, misalign_d;

   // The incrementer is shared by sequential flow and exception entry, and
   // is exported directly so fetch can use it without waiting a cycle.
   assign pc_plus2 = pc_q + 16'd2;

   // Next-state selection. Everything defaults to "hold" with the one-cycle
   // pulses cleared, so stall, halt and the HALTED state need no explicit
   // branch of their own beyond the state change. The if/else chain encodes
   // the request priority: halt > siic > rti > jmp > br_taken > sequential.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      redirect_d = 1'b0;
      misalign_d = 1'b0;

      if (state_q == RUN && !stall) begin
         if (halt) begin
            state_d = HALTED;
         end else if (siic) begin
            epc_d      = pc_plus2;
            pc_d       = EXC_VECTOR;
            redirect_d = 1'b1;
         end else if (rti) begin
            pc_d       = epc_q;
            redirect_d = 1'b1;
         end else if (jmp) begin
            pc_d       = {jmp_target[15:1], 1'b0};
            redirect_d = 1'b1;
            misalign_d = jmp_target[0];
         end else if (br_taken) begin
            pc_d       = {br_target[15:1], 1'b0};
            redirect_d = 1'b1;
            misalign_d = br_target[0];
         end else begin
            pc_d = pc_plus2;
         end
      end
   end

   // State register. Reset is asynchronous so the sequencer returns to a
   // known fetch address immediately, even while halted or stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         epc_q      <= 16'h0000;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         redirect_q <= redirect_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc       = pc_q;
   assign epc      = epc_q;
   assign halted   = (state_q == HALTED);
   assign redirect = redirect_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// TbPcSequencer -- directed self-checking bench for pc_sequencer
//
// Drives a linear sequence of hand-computed steps: reset, sequential flow,
// branch with odd target, exception entry/return, stall, wrap, halt and
// asynchronous reset out of HALTED. Each step applies inputs for one clock
// edge and then checks every output against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        halt;
   logic        siic;
   logic        rti;
   logic        jmp;
   logic [15:0] jmp_target;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic [15:0] epc;
   logic        halted;
   logic        redirect;
   logic        misalign;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(
      .RESET_PC   (16'h0000),
      .EXC_VECTOR (16'h0002)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .halt       (halt),
      .siic       (siic),
      .rti        (rti),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .pc         (pc),
      .pc_plus2   (pc_plus2),
      .epc        (epc),
      .halted     (halted),
      .redirect   (redirect),
      .misalign   (misalign)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle's worth of request inputs, let one rising edge consume
   // them, and return 1 time unit after the edge so outputs are settled.
   task automatic applyStimulus(input logic s, input logic h, input logic si,
                                input logic r, input logic j,
                                input logic [15:0] jt, input logic b,
                                input logic [15:0] bt);
      stall      = s;
      halt       = h;
      siic       = si;
      rti        = r;
      jmp        = j;
      jmp_target = jt;
      br_taken   = b;
      br_target  = bt;
      @(posedge clk);
      #1;
   endtask

   // Compare every output against its expected value; pc_plus2 is always
   // expected to be the wrapped successor of the expected pc.
   task automatic checkOutput(input string tag, input logic [15:0] exp_pc,
                              input logic [15:0] exp_epc, input logic exp_halted,
                              input logic exp_redirect, input logic exp_misalign);
      logic [15:0] exp_plus2;
      exp_plus2 = exp_pc + 16'd2;
      checks++;
      assert (pc === exp_pc) else begin
         errors++;
         $error("[TB] FAIL %s pc got=%h exp=%h", tag, pc, exp_pc);
      end
      checks++;
      assert (pc_plus2 === exp_plus2) else begin
         errors++;
         $error("[TB] FAIL %s pc_plus2 got=%h exp=%h", tag, pc_plus2, exp_plus2);
      end
      checks++;
      assert (epc === exp_epc) else begin
         errors++;
         $error("[TB] FAIL %s epc got=%h exp=%h", tag, epc, exp_epc);
      end
      checks++;
      assert (halted === exp_halted) else begin
         errors++;
         $error("[TB] FAIL %s halted got=%b exp=%b", tag, halted, exp_halted);
      end
      checks++;
      assert (redirect === exp_redirect) else begin
         errors++;
         $error("[TB] FAIL %s redirect got=%b exp=%b", tag, redirect, exp_redirect);
      end
      checks++;
      assert (misalign === exp_misalign) else begin
         errors++;
         $error("[TB] FAIL %s misalign got=%b exp=%b", tag, misalign, exp_misalign);
      end
   endtask

   // Directed sequence. Arguments to applyStimulus are:
   // stall, halt, siic, rti, jmp, jmp_target, br_taken, br_target.
   initial begin
      rst_n      = 1'b0;
      stall      = 1'b0;
      halt       = 1'b0;
      siic       = 1'b0;
      rti        = 1'b0;
      jmp        = 1'b0;
      jmp_target = 16'h0000;
      br_taken   = 1'b0;
      br_target  = 16'h0000;

      // Reset is asynchronous: outputs valid before any clock edge
      #1;
      checkOutput("reset_async", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      #11 rst_n = 1'b1;
      checkOutput("reset_release", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Four idle cycles: straight-line increment, no redirect
      $display("[TB] sequential flow");
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("seq_1", 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("seq_2", 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("seq_3", 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("seq_4", 16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Branch to odd target from 0010
      $display("[TB] branch with odd target");
      applyStimulus(0, 0, 0, 0, 1, 16'h0010, 0, 16'h0000);
      checkOutput("jmp_0010", 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0041);
      checkOutput("br_odd", 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("br_after", 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0);

      // jmp outranks br_taken
      applyStimulus(0, 0, 0, 0, 1, 16'h0050, 1, 16'h0060);
      checkOutput("jmp_over_br", 16'h0050, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Exception entry and return
      $display("[TB] exception entry/return");
      applyStimulus(0, 0, 0, 0, 1, 16'h0020, 0, 16'h0000);
      checkOutput("jmp_0020", 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1, 0, 1, 16'h0300, 0, 16'h0000);
      checkOutput("siic", 16'h0002, 16'h0022, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("handler", 16'h0004, 16'h0022, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 1, 1, 16'h0300, 0, 16'h0000);
      checkOutput("rti", 16'h0022, 16'h0022, 1'b0, 1'b1, 1'b0);

      // siic and rti together: siic wins, epc updated from 0022
      applyStimulus(0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
      checkOutput("siic_over_rti", 16'h0002, 16'h0024, 1'b0, 1'b1, 1'b0);

      // Stall holds state and clears pulses, requests ignored
      $display("[TB] stall");
      applyStimulus(0, 0, 0, 0, 1, 16'h0031, 0, 16'h0000);
      checkOutput("jmp_odd_0031", 16'h0030, 16'h0024, 1'b0, 1'b1, 1'b1);
      applyStimulus(1, 0, 0, 0, 1, 16'h0100, 0, 16'h0000);
      checkOutput("stall_1", 16'h0030, 16'h0024, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1, 1, 0, 1, 16'h0100, 0, 16'h0000);
      checkOutput("stall_2", 16'h0030, 16'h0024, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 1, 16'h0100, 0, 16'h0000);
      checkOutput("unstall_jmp", 16'h0100, 16'h0024, 1'b0, 1'b1, 1'b0);

      // Wrap at top of address space, then halt beats jmp
      $display("[TB] wrap and halt");
      applyStimulus(0, 0, 0, 0, 1, 16'hFFFC, 0, 16'h0000);
      checkOutput("jmp_fffc", 16'hFFFC, 16'h0024, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("seq_fffe", 16'hFFFE, 16'h0024, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("wrap_0000", 16'h0000, 16'h0024, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1, 1, 0, 1, 16'h0200, 0, 16'h0000);
      checkOutput("halt_wins", 16'h0000, 16'h0024, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("halted_siic", 16'h0000, 16'h0024, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 1, 1, 16'h0201, 1, 16'h0301);
      checkOutput("halted_jmp", 16'h0000, 16'h0024, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("halted_idle", 16'h0000, 16'h0024, 1'b1, 1'b0, 1'b0);

      // Move pc off 0000 can't happen while halted, so reset mid-cycle and
      // confirm the async clear of halted and epc before any clock edge
      $display("[TB] async reset from HALTED");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_halted", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      #1 rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("post_reset", 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Reset during a stall overrides the stall and a pending jmp
      applyStimulus(0, 0, 0, 0, 1, 16'h0456, 0, 16'h0000);
      checkOutput("jmp_0456", 16'h0456, 16'h0000, 1'b0, 1'b1, 1'b0);
      stall = 1'b1;
      jmp   = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_stall", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      #1 rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("post_reset_2", 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
